scan_bank_ctrl: RTL

Serial load/capture/unload controller for a flat bank of `CHAIN_LEN` scan-stitched DFFs in the APR test top. It takes parallel words over a valid/ready stream and shifts them into the chain one bit per cycle. It then pulses a one-cycle capture and shifts the chain contents back out as parallel words over a second valid/ready stream. This lets the placed flop bank be exercised and checked after APR without a tester.

---
 rtl/scan_bank_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/scan_bank_ctrl.sv
// scan_bank_ctrl: serial load/capture/unload controller for a flat scan-stitched
// flop bank. Parallel words arrive on a valid/ready stream and are shifted into
// the chain LSB-first. A one-cycle capture strobe follows. The chain is then
// shifted back out and repacked into parallel words on a second valid/ready
// stream.
//
// Parameters:
//   CHAIN_LEN  number of flops in the chain (>= 1)
//   W          stream word width (>= 1)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       begins a run when sampled in IDLE
//   in_valid/in_data/in_ready   load stream, bit 0 of each word shifted first
//   scan_en/scan_in/scan_out    chain shift enable, head data, tail data
//   capture                     one-cycle capture strobe to the bank
//   out_valid/out_data/out_ready unload stream, bit 0 is the first bit out
//   busy                        high in every state except IDLE
//   done                        one-cycle pulse at the end of a run
//   parity                      XOR of all unloaded bits
//
// Optional build macro:
//   SCAN_BANK_PARITY_EN  builds the unload parity accumulator; when undefined
//                        parity is tied to 0.
module scan_bank_ctrl #(
  parameter int unsigned CHAIN_LEN = 267,
  parameter int unsigned W         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         scan_en,
  output logic         scan_in,
  input  logic         scan_out,
  output logic         capture,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         parity
);

  localparam int unsigned CW        = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW        = $clog2(W + 1);
  localparam int unsigned NWORDS    = (CHAIN_LEN + W - 1) / W;
  localparam int unsigned WCW       = $clog2(NWORDS + 1);
  localparam int unsigned LAST_BITS = ((CHAIN_LEN % W) == 0) ? W : (CHAIN_LEN % W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_left;    // chain bits still to shift in the current phase
  logic [WCW-1:0]  words_left;  // load words still to accept
  logic [W-1:0]    hold;        // load holding register, drains from bit 0
  logic [BW-1:0]   hold_cnt;    // valid bits remaining in hold
  logic [W-1:0]    coll;        // unload collector
  logic [BW-1:0]   coll_cnt;    // bits already in the collector

  logic            load_shift;
  logic            in_fire;
  logic            out_free;
  logic            word_last;
  logic            unload_shift;
  logic [W-1:0]    coll_ins;

  // Load side: shift whenever the holding register has a bit; refill on its last bit.
  assign load_shift = (state == S_LOAD) && (hold_cnt != '0);
  assign in_ready   = (state == S_LOAD) && (hold_cnt <= BW'(1)) && (words_left != '0);
  assign in_fire    = in_valid && in_ready;

  // Unload side: the bit that completes a word goes straight to the output
  // register, so the chain only stalls when that register cannot take it.
  assign out_free     = !out_valid || out_ready;
  assign word_last    = (coll_cnt == BW'(W - 1)) || (bit_left == CW'(1));
  assign unload_shift = (state == S_UNLOAD) && (bit_left != '0) && (!word_last || out_free);

  assign scan_en = load_shift || unload_shift;
  assign scan_in = hold[0];
  assign capture = (state == S_CAPTURE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  // Collector contents with the current scan_out bit inserted at its slot.
  always_comb begin
    coll_ins = coll;
    for (int unsigned i = 0; i < W; i++) begin
      if (coll_cnt == BW'(i)) coll_ins[i] = scan_out;
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_left   <= '0;
      words_left <= '0;
      hold       <= '0;
      hold_cnt   <= '0;
      coll       <= '0;
      coll_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            bit_left   <= CW'(CHAIN_LEN);
            words_left <= WCW'(NWORDS);
            hold_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            hold       <= in_data;
            hold_cnt   <= (words_left == WCW'(1)) ? BW'(LAST_BITS) : BW'(W);
            words_left <= words_left - WCW'(1);
          end else if (load_shift) begin
            hold     <= hold >> 1;
            hold_cnt <= hold_cnt - BW'(1);
          end
          if (load_shift) begin
            bit_left <= bit_left - CW'(1);
            if (bit_left == CW'(1)) state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          state    <= S_UNLOAD;
          bit_left <= CW'(CHAIN_LEN);
          coll     <= '0;
          coll_cnt <= '0;
        end
        S_UNLOAD: begin
          if (unload_shift) begin
            bit_left <= bit_left - CW'(1);
            if (word_last) begin
              // Collector is kept zeroed between words, which pads the final word.
              out_data  <= coll_ins;
              out_valid <= 1'b1;
              coll      <= '0;
              coll_cnt  <= '0;
            end else begin
              coll     <= coll_ins;
              coll_cnt <= coll_cnt + BW'(1);
            end
          end else if ((bit_left == '0) && out_valid && out_ready) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_BANK_PARITY_EN
  logic parity_q;

  // Running XOR of unloaded bits; cleared when a run starts, held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      parity_q <= 1'b0;
    end else if (unload_shift) begin
      parity_q <= parity_q ^ scan_out;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule
